// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches and buffers responses as {instr, pc}.
// Optional same-cycle response-to-decode bypass is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [PW-1:0]   PONE    = PW'(1);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_base;
  logic [CW-1:0]   count, inflight, drop, occupancy;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            req_fire, rsp_fire, rsp_take, bypass, push, pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1;
  // a raised valid (and its payload) holds until that transfer or a redirect.
  always_comb begin
    redirect_base  = redirect_pc & ~XLEN'(3);
    occupancy      = count + inflight + drop;
    imem_req_valid = rst && !redirect_valid && (occupancy < DEPTH_C);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are stray and ignored entirely.
    rsp_fire       = imem_rsp_valid && ((inflight != '0) || (drop != '0));
    rsp_take       = rsp_fire && (drop == '0) && !redirect_valid;
`ifdef IFQ_BYPASS_EN
    bypass         = rsp_take && (count == '0);
`else
    bypass         = 1'b0;
`endif
    out_valid      = rst && !redirect_valid && ((count != '0) || bypass);
    out_instr      = bypass ? imem_rsp_data : instr_mem[rd_ptr];
    out_pc         = bypass ? rsp_pc : pc_mem[rd_ptr];
    pop            = out_valid && out_ready && !bypass;
    push           = rsp_take && !(bypass && out_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      // A response landing now retires one of the old outstanding requests.
      drop     <= drop + inflight - (rsp_fire ? ONE : '0);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + FOUR;
      if (rsp_take) rsp_pc <= rsp_pc + FOUR;
      if (push)     wr_ptr <= wr_ptr + PONE;
      if (pop)      rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      case ({req_fire, rsp_take})
        2'b10:   inflight <= inflight + ONE;
        2'b01:   inflight <= inflight - ONE;
        default: inflight <= inflight;
      endcase
      if (rsp_fire && (drop != '0)) drop <= drop - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirects, stray responses
// and the optional IFQ_BYPASS_EN timing.
module tb_instr_fetch_queue;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          auto_mem, sb_on, req_chk;
  logic [31:0] exp_req;
  int          n_req, ncyc;

  instr_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: sample handshakes before the edge, then the 1-cycle memory model responds.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    logic [31:0] e;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (acc) begin
      n_req++;
      if (req_chk) begin
        check("req_addr", a, exp_req);
        exp_req += 32'd4;
      end
    end
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra_pop observed_pc=%h expected=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_instr", out_instr, 32'hA000_0000 | e);
      end
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = 32'hA000_0000 | a;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    sb_on = 0; req_chk = 0; auto_mem = 0;
    @(negedge clk);
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    rst = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_req_valid", imem_req_valid, 1);
    check("rel_req_addr", imem_req_addr, 32'h0);
  endtask

  // driver / stimulus
  initial begin
    rst = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    auto_mem = 0; sb_on = 0; req_chk = 0; exp_req = '0; n_req = 0;

    // A: streaming with 1-cycle memory and decode always ready
    do_reset();
    imem_req_ready = 1; out_ready = 1; auto_mem = 1;
    req_chk = 1; exp_req = 32'h0; sb_on = 1; n_req = 0; ncyc = 0;
    exp_q = {};
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
    settle();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      cycle();
      ncyc++;
    end
    check("a_drained", exp_q.size(), 0);
`ifdef IFQ_BYPASS_EN
    check("a_cycles", ncyc, 11);
`else
    check("a_cycles", ncyc, 12);
`endif
    check("a_req_per_cycle", n_req, ncyc);

    // B: decode stalled fills exactly DEPTH entries, then drains in order (reset mid-run first)
    do_reset();
    imem_req_ready = 1; out_ready = 0; auto_mem = 1;
    req_chk = 1; exp_req = 32'h0; n_req = 0;
    settle();
    for (int i = 0; i < 8; i++) cycle();
    check("b_req_cnt", n_req, 4);
    check("b_stall_req_valid", imem_req_valid, 0);
    check("b_head_valid", out_valid, 1);
    check("b_head_pc", out_pc, 32'h0);
    out_ready = 1; sb_on = 1;
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    settle();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle();
    check("b_drained", exp_q.size(), 0);

    // H: held request stays stable; stray response with nothing outstanding is ignored
    do_reset();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0BAD;
    settle();
    check("h_hold_valid0", imem_req_valid, 1);
    check("h_hold_addr0", imem_req_addr, 32'h0);
    check("h_stray_out0", out_valid, 0);
    cycle();
    imem_rsp_valid = 0;
    settle();
    check("h_stray_out1", out_valid, 0);
    check("h_hold_valid1", imem_req_valid, 1);
    check("h_hold_addr1", imem_req_addr, 32'h0);
    cycle();
    imem_req_ready = 1;
    settle();
    cycle();
    imem_req_ready = 0;
    settle();
    check("h_adv_addr", imem_req_addr, 32'h4);

    // C: two requests in flight at 0x10/0x14, redirect to 0x100 discards both
    do_reset();
    redirect_valid = 1; redirect_pc = 32'h10; imem_req_ready = 1;
    settle();
    check("c_redir_noreq", imem_req_valid, 0);
    cycle();
    redirect_valid = 0;
    settle();
    check("c_req10_valid", imem_req_valid, 1);
    check("c_req10_addr", imem_req_addr, 32'h10);
    cycle();
    settle();
    check("c_req14_addr", imem_req_addr, 32'h14);
    cycle();
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    settle();
    check("c_redir_req_valid", imem_req_valid, 0);
    check("c_redir_out_valid", out_valid, 0);
    cycle();
    redirect_valid = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_0010;
    settle();
    check("c_empty_after", out_valid, 0);
    check("c_new_req_valid", imem_req_valid, 1);
    check("c_new_req_addr", imem_req_addr, 32'h100);
    cycle();
    imem_rsp_data = 32'hDEAD_0014;
    settle();
    check("c_drop2_out", out_valid, 0);
    cycle();
    imem_rsp_valid = 0; imem_req_ready = 1;
    settle();
    check("c_dropped_out", out_valid, 0);
    cycle();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    settle();
    cycle();
    imem_rsp_valid = 0;
    settle();
    check("c_out_valid", out_valid, 1);
    check("c_out_pc", out_pc, 32'h100);
    check("c_out_instr", out_instr, 32'h0000_0013);

    // F: redirect coinciding with a response and a ready decode
    do_reset();
    imem_req_ready = 1;
    settle();
    cycle();
    imem_rsp_valid = 1; imem_rsp_data = 32'h1111_0000;
    settle();
    cycle();
    imem_req_ready = 0; imem_rsp_valid = 0;
    settle();
    check("f_head_valid", out_valid, 1);
    check("f_head_pc", out_pc, 32'h0);
    check("f_head_instr", out_instr, 32'h1111_0000);
    cycle();
    redirect_valid = 1; redirect_pc = 32'h40;
    imem_rsp_valid = 1; imem_rsp_data = 32'h2222_0004; out_ready = 1;
    settle();
    check("f_redir_out_valid", out_valid, 0);
    cycle();
    redirect_valid = 0; imem_rsp_valid = 0; out_ready = 0; imem_req_ready = 1;
    settle();
    check("f_flushed", out_valid, 0);
    check("f_req_valid", imem_req_valid, 1);
    check("f_req_addr", imem_req_addr, 32'h40);
    cycle();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    settle();
    cycle();
    imem_rsp_valid = 0;
    settle();
    check("f_out_valid", out_valid, 1);
    check("f_out_pc", out_pc, 32'h40);
    check("f_out_instr", out_instr, 32'h0000_0013);

    // E: unaligned redirect targets and response-to-decode latency
    do_reset();
    out_ready = 1; redirect_valid = 1; redirect_pc = 32'h103;
    settle();
    check("e_redir_noreq", imem_req_valid, 0);
    cycle();
    redirect_valid = 0;
    settle();
    check("e_align_addr", imem_req_addr, 32'h100);
    cycle();
    redirect_valid = 1; redirect_pc = 32'h23;
    settle();
    cycle();
    redirect_valid = 0; imem_req_ready = 1;
    settle();
    check("e_req20_addr", imem_req_addr, 32'h20);
    cycle();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0013;
    settle();
`ifdef IFQ_BYPASS_EN
    check("e_rsp_cycle_valid", out_valid, 1);
    check("e_rsp_cycle_pc", out_pc, 32'h20);
    check("e_rsp_cycle_instr", out_instr, 32'h0000_0013);
`else
    check("e_rsp_cycle_valid", out_valid, 0);
`endif
    cycle();
    imem_rsp_valid = 0;
    settle();
`ifdef IFQ_BYPASS_EN
    check("e_next_valid", out_valid, 0);
`else
    check("e_next_valid", out_valid, 1);
    check("e_next_pc", out_pc, 32'h20);
    check("e_next_instr", out_instr, 32'h0000_0013);
`endif
    cycle();

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of the PC and address buses.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, a power of two of at least 2; sets queue entries and the outstanding-request limit.
REQ-004 SHALL have these ports, listed as name, direction, width, meaning:
  clk  input  1  single clock; all state updates on the rising edge
  rst  input  1  asynchronous, active-low reset
  imem_req_valid  output  1  fetch request valid
  imem_req_addr  output  XLEN  fetch address, word-aligned
  imem_req_ready  input  1  instruction memory accepts the request
  imem_rsp_valid  input  1  response valid; responses return in order, at least 1 cycle after acceptance
  imem_rsp_data  input  32  instruction word
  redirect_valid  input  1  branch/jump redirect from the datapath
  redirect_pc  input  XLEN  new fetch PC
  out_valid  output  1  instruction available to decode
  out_instr  output  32  head instruction
  out_pc  output  XLEN  PC of the head instruction
  out_ready  input  1  decode consumes the head

Function
REQ-005 SHALL hold fetch_pc; a request handshake (imem_req_valid and imem_req_ready) SHALL advance fetch_pc by 4, wrapping modulo 2^XLEN.
REQ-006 SHALL drive imem_req_addr = fetch_pc and imem_req_valid = (count + inflight + drop < DEPTH) and not redirect_valid, so no response can overflow the queue.
REQ-007 SHALL increment inflight per accepted request and decrement it per non-dropped response; a response SHALL be pushed into the queue with out-of-band pc = rsp_pc, then rsp_pc increments by 4.
REQ-008 SHALL implement a DEPTH-entry FIFO of {instr, pc}; out_valid = (count != 0) and not redirect_valid; out_instr and out_pc SHALL come from the head entry.
REQ-009 SHALL pop the head on out_valid and out_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-010 On redirect_valid SHALL: flush the queue (count = 0), set fetch_pc and rsp_pc to {redirect_pc[XLEN-1:2],2'b00}, set drop = drop + inflight, and set inflight = 0, all at the same edge.
REQ-011 While drop != 0, each imem_rsp_valid SHALL decrement drop and discard the data, with no push.
REQ-012 A response arriving in the redirect cycle SHALL be discarded and counted against the pre-redirect inflight/drop total.
REQ-013 No request SHALL be issued in the redirect cycle; the first request from the new PC SHALL be possible on the following cycle.
REQ-014 An imem_rsp_valid with inflight = 0 and drop = 0 is illegal; it SHALL be ignored.
REQ-015 Held request: once asserted, imem_req_valid and imem_req_addr SHALL remain stable until accepted, unless a redirect occurs.

Reset
REQ-016 While rst = 0 SHALL asynchronously force: fetch_pc = rsp_pc = RESET_PC, count = inflight = drop = 0, FIFO pointers = 0, imem_req_valid = 0, out_valid = 0.
REQ-017 After release SHALL assert imem_req_valid with imem_req_addr = RESET_PC in the first cycle with rst = 1; a reset mid-operation SHALL abandon all queued and in-flight state without further output.

Configuration
REQ-018 Macro IFQ_BYPASS_EN, when defined, SHALL enable bypass: if count = 0, imem_rsp_valid, and the response is not dropped, out_valid SHALL be 1 in the same cycle with out_instr = imem_rsp_data and out_pc = rsp_pc; if out_ready is also 1, no push occurs.
REQ-019 Without IFQ_BYPASS_EN, a response SHALL always be pushed and becomes visible at out_* one cycle later (minimum fetch-to-decode latency of 1 cycle after the response).

Verification
REQ-020 Reset release, memory with 1-cycle latency, out_ready = 1 -> requests to 0x0, 0x4, 0x8, ...; out_pc sequence 0x0, 0x4, 0x8 with matching instructions, one per cycle in steady state.
REQ-021 out_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0, count = 4; then out_ready = 1 -> drain in order and fetching resumes.
REQ-022 Two requests in flight (0x10, 0x14), redirect_pc = 0x100 -> both responses discarded; next out_pc = 0x100; queue is empty in the cycle after the redirect.
REQ-023 redirect_pc = 0x103 -> fetch and out_pc use 0x100.
REQ-024 Redirect in the same cycle as imem_rsp_valid and out_ready -> no pop or push occurs, out_valid = 0 in that cycle, and the response is discarded.
REQ-025 With IFQ_BYPASS_EN, empty queue, response 0x00000013 at rsp_pc 0x20 -> out_valid = 1, out_instr = 0x00000013, out_pc = 0x20 in the same cycle; without the macro, this appears one cycle later.
